// File: rtl/mem_pkg.sv
// Shared defaults for the generic synchronous memory: bus widths and depth derivation.
package mem_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  // Full address space of an ADDR_WIDTH-bit bus.
  function automatic int unsigned depth_for(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/generic_sync_mem.sv
// Single-port synchronous RAM with chip-select, write-enable and output-enable.
// Registered read data (one cycle latency); write wins over read when both are requested.
module generic_sync_mem
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = depth_for(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
);

  // One extra bit so the range compare still works when DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;

  assign in_range = ({1'b0, address} < DEPTH_LIM);
  assign wr_en    = cs && we;
  assign rd_en    = cs && !we && oe;

  // Array has no reset so it maps onto block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en && in_range) begin
      mem_q[address] <= data_in;
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    if (rd_en) begin
      data_out_d = in_range ? mem_q[address] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_generic_sync_mem.sv
// Self-checking bench: full-depth and DEPTH=200 instances driven in parallel,
// compared against an array model of the memory rules.
module tb_generic_sync_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       cs, we, oe;
  logic [7:0] dout;
  logic [7:0] dout200;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [7:0] ref_mem   [256];
  bit         ref_known [256];
  logic [7:0] exp_out, exp_out200;
  bit         exp_known, exp_known200;

  always #5 clk = ~clk;

  generic_sync_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
    .data_out(dout), .cs(cs), .we(we), .oe(oe)
  );

  generic_sync_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(200)) dut200 (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
    .data_out(dout200), .cs(cs), .we(we), .oe(oe)
  );

  // Drive one access at the falling edge, apply it to the model at the rising edge.
  task automatic cycle(input logic c, input logic w, input logic o,
                       input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = c; we = w; oe = o; address = a; data_in = d;
    @(posedge clk);
    if (c && w) begin
      ref_mem[a]   = d;
      ref_known[a] = 1'b1;
    end else if (c && o) begin
      exp_out   = ref_mem[a];
      exp_known = ref_known[a];
      if (a < 8'd200) begin
        exp_out200   = ref_mem[a];
        exp_known200 = ref_known[a];
      end else begin
        exp_out200   = 8'h00;
        exp_known200 = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs = 0; we = 0; oe = 0; address = 0; data_in = 0;
    #12;
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_init: got %h want 00", dout); end
    checks++;
    if (dout200 !== 8'h00) begin errors++; $display("FAIL reset_init200: got %h want 00", dout200); end
    @(negedge clk); rst_n = 1'b1;
    exp_out = 8'h00; exp_known = 1; exp_out200 = 8'h00; exp_known200 = 1;
    cycle(1, 1, 0, 8'h05, 8'hAB);
    cycle(1, 0, 1, 8'h05, 8'h00);
    checks++;
    if (dout !== 8'hAB) begin errors++; $display("FAIL reset_preload: got %h want AB", dout); end
    // Mid-cycle assertion, well away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_async: got %h want 00", dout); end
    checks++;
    if (dout200 !== 8'h00) begin errors++; $display("FAIL reset_async200: got %h want 00", dout200); end
    exp_out = 8'h00; exp_out200 = 8'h00;
    @(negedge clk); cs = 0; rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 256; i++) begin
      cycle(1, 1, 0, 8'(i), 8'($urandom_range(0, 255)));
    end
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL fill_hold: got %h want 00", dout); end
  endtask

  task automatic test_seq();
    logic [7:0] vals [4];
    vals[0] = 8'hFF; vals[1] = 8'hBB; vals[2] = 8'hCC; vals[3] = 8'hDD;
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 8'(i), vals[i]);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 1, 8'(i), 8'h00);
      checks++;
      if (dout !== vals[i]) begin errors++; $display("FAIL seq_read[%0d]: got %h want %h", i, dout, vals[i]); end
      checks++;
      if (dout200 !== vals[i]) begin errors++; $display("FAIL seq_read200[%0d]: got %h want %h", i, dout200, vals[i]); end
    end
  endtask

  task automatic test_cs_off();
    cycle(0, 1, 0, 8'h01, 8'h55);
    cycle(1, 0, 1, 8'h01, 8'h00);
    checks++;
    if (dout !== 8'hBB) begin errors++; $display("FAIL cs_off_write: got %h want BB", dout); end
    cycle(0, 0, 1, 8'h03, 8'h00);
    checks++;
    if (dout !== 8'hBB) begin errors++; $display("FAIL cs_off_read_hold: got %h want BB", dout); end
  endtask

  task automatic test_conflict();
    cycle(1, 1, 1, 8'h02, 8'h77);
    checks++;
    if (dout !== 8'hBB) begin errors++; $display("FAIL conflict_hold: got %h want BB", dout); end
    cycle(1, 0, 1, 8'h02, 8'h00);
    checks++;
    if (dout !== 8'h77) begin errors++; $display("FAIL conflict_write: got %h want 77", dout); end
  endtask

  task automatic test_raw();
    cycle(1, 1, 0, 8'h10, 8'h3C);
    cycle(1, 0, 1, 8'h10, 8'h00);
    checks++;
    if (dout !== 8'h3C) begin errors++; $display("FAIL raw: got %h want 3C", dout); end
    checks++;
    if (dout200 !== 8'h3C) begin errors++; $display("FAIL raw200: got %h want 3C", dout200); end
  endtask

  task automatic test_boundary();
    cycle(1, 1, 0, 8'hFF, 8'hA5);
    cycle(1, 0, 1, 8'hFF, 8'h00);
    checks++;
    if (dout !== 8'hA5) begin errors++; $display("FAIL top_addr: got %h want A5", dout); end
    checks++;
    if (dout200 !== 8'h00) begin errors++; $display("FAIL oor_FF_200: got %h want 00", dout200); end
    cycle(1, 0, 1, 8'h10, 8'h00);
    cycle(1, 1, 0, 8'hF0, 8'h99);
    cycle(1, 0, 1, 8'hF0, 8'h00);
    checks++;
    if (dout200 !== 8'h00) begin errors++; $display("FAIL oor_F0_200: got %h want 00", dout200); end
    checks++;
    if (dout !== 8'h99) begin errors++; $display("FAIL F0_full: got %h want 99", dout); end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 8'h10, 8'h00);
      checks++;
      if (dout !== 8'h99) begin errors++; $display("FAIL idle_hold[%0d]: got %h want 99", i, dout); end
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int i = 0; i < 500; i++) begin
      a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(190, 255));
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) != 0),
            a, 8'($urandom_range(0, 255)));
      if (exp_known) begin
        checks++;
        if (dout !== exp_out) begin errors++; $display("FAIL random[%0d]: got %h want %h", i, dout, exp_out); end
      end
      if (exp_known200) begin
        checks++;
        if (dout200 !== exp_out200) begin errors++; $display("FAIL random200[%0d]: got %h want %h", i, dout200, exp_out200); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 8'h00;
      ref_known[i] = 1'b0;
    end
    test_reset();
    test_fill();
    test_seq();
    test_cs_off();
    test_conflict();
    test_raw();
    test_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
